dmem_responder: RTL

Memory-side responder for the load/store stage. It accepts byte-enabled read/write requests over a valid/ready request channel, inserts a configurable number of wait states, and returns read data or completion status over a valid/ready response channel. It replaces the single-cycle data memory wherever the pipeline must tolerate multi-cycle memory latency.

---
 rtl/dmem_responder.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data memory responder for the load/store stage.
// Accepts byte-enabled loads/stores on a valid/ready request channel, waits
// LATENCY cycles, then presents read data or completion status on a
// valid/ready response channel.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   req_valid/req_ready         request handshake
//   req_we, req_addr            store select, byte address
//   req_wdata, req_be           lane-aligned store data, byte-lane enables
//   rsp_valid/rsp_ready         response handshake
//   rsp_rdata, rsp_err          full read word (0 for stores/errors), reject flag
// Optional: define DMEM_ALIGN_CHECK_EN to reject byte enables that do not
// match addr[1:0] (byte, aligned halfword, aligned word only).
module dmem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
    localparam bit NO_WAIT = (LATENCY == 0);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic [31:0] r_mem [0:DEPTH-1];

    logic                  w_acc_now;
    logic                  w_a_we;
    logic [31:0]           w_a_addr;
    logic [31:0]           w_a_wdata;
    logic [3:0]            w_a_be;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic                  w_range_err;
    logic                  w_align_ok;
    logic                  w_err;
    logic                  w_wr_en;
    logic [31:0]           w_rd_word;

    // With zero wait states the access happens at the accept edge, so the
    // access operands come straight from the request port.
    assign w_a_we    = NO_WAIT ? req_we    : r_we;
    assign w_a_addr  = NO_WAIT ? req_addr  : r_addr;
    assign w_a_wdata = NO_WAIT ? req_wdata : r_wdata;
    assign w_a_be    = NO_WAIT ? req_be    : r_be;

    assign w_acc_now = NO_WAIT ? (r_state == S_IDLE && req_valid)
                               : (r_state == S_WAIT && r_cnt == 4'd0);

    assign w_idx       = w_a_addr[ADDR_WIDTH+1:2];
    assign w_range_err = |(w_a_addr >> (ADDR_WIDTH + 2));

    always_comb begin
        w_align_ok = 1'b1;
`ifdef DMEM_ALIGN_CHECK_EN
        unique case (w_a_addr[1:0])
            2'd0: w_align_ok = (w_a_be == 4'b0001) || (w_a_be == 4'b0011) ||
                               (w_a_be == 4'b1111);
            2'd1: w_align_ok = (w_a_be == 4'b0010);
            2'd2: w_align_ok = (w_a_be == 4'b0100) || (w_a_be == 4'b1100);
            2'd3: w_align_ok = (w_a_be == 4'b1000);
            default: w_align_ok = 1'b0;
        endcase
`endif
    end

    assign w_err     = w_range_err || (w_a_be == 4'b0000) || !w_align_ok;
    // rst gates the write so a reset on the access edge leaves RAM untouched.
    assign w_wr_en   = !rst && w_acc_now && w_a_we && !w_err;
    assign w_rd_word = r_mem[w_idx];

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (w_a_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_a_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_we      <= 1'b0;
            r_addr    <= 32'd0;
            r_wdata   <= 32'd0;
            r_be      <= 4'd0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_we      <= req_we;
                        r_addr    <= req_addr;
                        r_wdata   <= req_wdata;
                        r_be      <= req_be;
                        req_ready <= 1'b0;
                        if (NO_WAIT) begin
                            r_state   <= S_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= w_err;
                            rsp_rdata <= (w_err || w_a_we) ? 32'd0 : w_rd_word;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= LAT_M1;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state   <= S_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= w_err;
                        rsp_rdata <= (w_err || w_a_we) ? 32'd0 : w_rd_word;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_state   <= S_IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
